// File: rtl/decode_stage.sv
// RV32I decode stage with one registered output bundle.
// Fetch and execute both use valid/ready handshakes. Flush clears the
// held bundle. A saturating counter tracks illegal bundles handed downstream.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [31:0]      i_instr,
   input  logic [XLEN-1:0]  i_pc,
   input  logic             i_flush,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [XLEN-1:0]  o_out_pc,
   output logic [4:0]       o_rd,
   output logic [4:0]       o_rs1,
   output logic [4:0]       o_rs2,
   output logic [XLEN-1:0]  o_imm,
   output logic [3:0]       o_alu_control,
   output logic             o_alu_src_imm,
   output logic             o_alu_src_pc,
   output logic             o_regwrite_control,
   output logic             o_mem_read,
   output logic             o_mem_write,
   output logic             o_illegal,
   output logic [CNT_W-1:0] o_illegal_count
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_NONE  = 4'b1111;

   // Index is {funct7[5], funct3}. Selectors that no OP encoding reaches fall to none.
   function automatic logic [3:0] alu_sel(input logic [3:0] sel);
      case (sel)
         4'b0_000: alu_sel = 4'b0010;
         4'b1_000: alu_sel = 4'b0100;
         4'b0_001: alu_sel = 4'b0011;
         4'b0_010: alu_sel = 4'b1000;
         4'b0_011: alu_sel = 4'b0110;
         4'b0_100: alu_sel = 4'b0111;
         4'b0_101: alu_sel = 4'b0101;
         4'b1_101: alu_sel = 4'b1001;
         4'b0_110: alu_sel = 4'b0001;
         4'b0_111: alu_sel = 4'b0000;
         default:  alu_sel = ALU_NONE;
      endcase
   endfunction

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic [31:0]     w_i_imm;
   logic [31:0]     w_s_imm;
   logic [31:0]     w_u_imm;
   logic [31:0]     w_shamt;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm_ext;
   logic [4:0]      w_rs1;
   logic [3:0]      w_alu;
   logic            w_src_imm;
   logic            w_src_pc;
   logic            w_regwrite;
   logic            w_mem_read;
   logic            w_mem_write;
   logic            w_illegal;
   logic            w_accept;

   logic             r_valid;
   logic [XLEN-1:0]  r_pc;
   logic [4:0]       r_rd;
   logic [4:0]       r_rs1;
   logic [4:0]       r_rs2;
   logic [XLEN-1:0]  r_imm;
   logic [3:0]       r_alu;
   logic             r_src_imm;
   logic             r_src_pc;
   logic             r_regwrite;
   logic             r_mem_read;
   logic             r_mem_write;
   logic             r_illegal;
   logic [CNT_W-1:0] r_cnt;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   assign w_funct7 = i_instr[31:25];
   assign w_i_imm  = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_s_imm  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_u_imm  = {i_instr[31:12], 12'h000};
   assign w_shamt  = {27'd0, i_instr[24:20]};
   // Every immediate is built as 32 bits and sign-extended from bit 31 to XLEN.
   assign w_imm_ext = XLEN'($signed(w_imm32));

   assign o_in_ready = !r_valid || i_out_ready;
   assign w_accept   = i_in_valid && o_in_ready;

   // Decode the incoming instruction into its control bundle; unknown encodings become a bare illegal bundle.
   always_comb begin
      w_alu       = ALU_NONE;
      w_imm32     = '0;
      w_rs1       = i_instr[19:15];
      w_src_imm   = 1'b0;
      w_src_pc    = 1'b0;
      w_regwrite  = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_illegal   = 1'b1;
      case (w_opcode)
         OPC_OP: begin
            if (w_funct7 == 7'h00 ||
                (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
               w_alu      = alu_sel({w_funct7[5], w_funct3});
               w_regwrite = 1'b1;
               w_illegal  = 1'b0;
            end
         end
         OPC_OPIMM: begin
            w_illegal = 1'b0;
            w_alu     = alu_sel({1'b0, w_funct3});
            w_imm32   = w_i_imm;
            if (w_funct3 == 3'b001) begin
               w_imm32   = w_shamt;
               w_illegal = (w_funct7 != 7'h00);
            end else if (w_funct3 == 3'b101) begin
               w_imm32   = w_shamt;
               w_alu     = alu_sel({w_funct7[5], w_funct3});
               w_illegal = !(w_funct7 == 7'h00 || w_funct7 == 7'h20);
            end
            w_src_imm  = 1'b1;
            w_regwrite = 1'b1;
         end
         OPC_LOAD: begin
            if (w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
               w_alu      = ALU_ADD;
               w_imm32    = w_i_imm;
               w_src_imm  = 1'b1;
               w_mem_read = 1'b1;
               w_regwrite = 1'b1;
               w_illegal  = 1'b0;
            end
         end
         OPC_STORE: begin
            if (w_funct3 inside {3'b000, 3'b001, 3'b010}) begin
               w_alu       = ALU_ADD;
               w_imm32     = w_s_imm;
               w_src_imm   = 1'b1;
               w_mem_write = 1'b1;
               w_illegal   = 1'b0;
            end
         end
         OPC_LUI: begin
            w_alu      = ALU_ADD;
            w_rs1      = 5'd0;
            w_imm32    = w_u_imm;
            w_src_imm  = 1'b1;
            w_regwrite = 1'b1;
            w_illegal  = 1'b0;
         end
         OPC_AUIPC: begin
            w_alu      = ALU_ADD;
            w_imm32    = w_u_imm;
            w_src_imm  = 1'b1;
            w_src_pc   = 1'b1;
            w_regwrite = 1'b1;
            w_illegal  = 1'b0;
         end
         default: ;
      endcase
      // Illegal bundles carry only pc and register indices.
      if (w_illegal) begin
         w_alu       = ALU_NONE;
         w_imm32     = '0;
         w_src_imm   = 1'b0;
         w_src_pc    = 1'b0;
         w_regwrite  = 1'b0;
         w_mem_read  = 1'b0;
         w_mem_write = 1'b0;
      end
   end

   // Output bundle register: flush beats accept, and an unreplaced handoff empties the stage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_imm       <= '0;
         r_alu       <= ALU_NONE;
         r_src_imm   <= 1'b0;
         r_src_pc    <= 1'b0;
         r_regwrite  <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid     <= 1'b1;
         r_pc        <= i_pc;
         r_rd        <= i_instr[11:7];
         r_rs1       <= w_rs1;
         r_rs2       <= i_instr[24:20];
         r_imm       <= w_imm_ext;
         r_alu       <= w_alu;
         r_src_imm   <= w_src_imm;
         r_src_pc    <= w_src_pc;
         r_regwrite  <= w_regwrite;
         r_mem_read  <= w_mem_read;
         r_mem_write <= w_mem_write;
         r_illegal   <= w_illegal;
      end else if (r_valid && i_out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Count illegal bundles as execute takes them; a flushed bundle never counts as handed off.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (!i_flush && r_valid && i_out_ready && r_illegal && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_out_valid        = r_valid;
   assign o_out_pc           = r_pc;
   assign o_rd               = r_rd;
   assign o_rs1              = r_rs1;
   assign o_rs2              = r_rs2;
   assign o_imm              = r_imm;
   assign o_alu_control      = r_alu;
   assign o_alu_src_imm      = r_src_imm;
   assign o_alu_src_pc       = r_src_pc;
   assign o_regwrite_control = r_regwrite;
   assign o_mem_read         = r_mem_read;
   assign o_mem_write        = r_mem_write;
   assign o_illegal          = r_illegal;
   assign o_illegal_count    = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage. Expected bundles are queued when fetch hands over an instruction.
// They are compared when execute takes the bundle. A second instance with a 2-bit counter
// shares the same stimulus to exercise saturation.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        si;
      logic        sp;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        il;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_in_valid = 1'b0;
   logic [31:0] i_instr = '0;
   logic [31:0] i_pc = '0;
   logic        i_flush = 1'b0;
   logic        i_out_ready = 1'b1;

   logic        o_in_ready, o_out_valid;
   logic [31:0] o_out_pc, o_imm;
   logic [4:0]  o_rd, o_rs1, o_rs2;
   logic [3:0]  o_alu_control;
   logic        o_alu_src_imm, o_alu_src_pc, o_regwrite_control, o_mem_read, o_mem_write, o_illegal;
   logic [15:0] o_illegal_count;

   logic        o2_in_ready, o2_out_valid;
   logic [31:0] o2_out_pc, o2_imm;
   logic [4:0]  o2_rd, o2_rs1, o2_rs2;
   logic [3:0]  o2_alu_control;
   logic        o2_alu_src_imm, o2_alu_src_pc, o2_regwrite_control, o2_mem_read, o2_mem_write, o2_illegal;
   logic [1:0]  o2_illegal_count;

   int   checks = 0;
   int   errors = 0;
   int   n_push = 0;
   int   n_pop = 0;
   int   exp_cnt = 0;
   exp_t q[$];
   exp_t mon_e;
   exp_t kill_e;
   exp_t held_e;
   exp_t w_got;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .CNT_W(16)) u_dut (
      .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_out_valid(o_out_valid),
      .i_out_ready(i_out_ready), .o_out_pc(o_out_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
      .o_imm(o_imm), .o_alu_control(o_alu_control), .o_alu_src_imm(o_alu_src_imm),
      .o_alu_src_pc(o_alu_src_pc), .o_regwrite_control(o_regwrite_control),
      .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_illegal(o_illegal),
      .o_illegal_count(o_illegal_count)
   );

   decode_stage #(.XLEN(32), .CNT_W(2)) u_dut2 (
      .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o2_in_ready),
      .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_out_valid(o2_out_valid),
      .i_out_ready(i_out_ready), .o_out_pc(o2_out_pc), .o_rd(o2_rd), .o_rs1(o2_rs1), .o_rs2(o2_rs2),
      .o_imm(o2_imm), .o_alu_control(o2_alu_control), .o_alu_src_imm(o2_alu_src_imm),
      .o_alu_src_pc(o2_alu_src_pc), .o_regwrite_control(o2_regwrite_control),
      .o_mem_read(o2_mem_read), .o_mem_write(o2_mem_write), .o_illegal(o2_illegal),
      .o_illegal_count(o2_illegal_count)
   );

   assign w_got = {o_out_pc, o_rd, o_rs1, o_rs2, o_imm, o_alu_control, o_alu_src_imm,
                   o_alu_src_pc, o_regwrite_control, o_mem_read, o_mem_write, o_illegal};

   // fl = {alu_src_imm, alu_src_pc, regwrite, mem_read, mem_write, illegal}
   function automatic exp_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [3:0] alu, input logic [5:0] fl);
      exp_t e;
      e.pc  = '0;
      e.rd  = rd;
      e.rs1 = rs1;
      e.rs2 = rs2;
      e.imm = imm;
      e.alu = alu;
      {e.si, e.sp, e.rw, e.mr, e.mw, e.il} = fl;
      return e;
   endfunction

   // Scoreboard side: compare each bundle on the cycle execute takes it.
   always @(negedge clk) begin
      if (!i_rst && !i_flush && o_out_valid && i_out_ready) begin
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_bundle got pc %h exp none", o_out_pc);
         end
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            n_pop++;
            checks++;
            assert (w_got === mon_e) else begin
               errors++;
               $error("FAIL bundle got %h exp %h", w_got, mon_e);
            end
            if (mon_e.il) exp_cnt++;
         end
      end
   end

   task automatic send(input logic [31:0] ins, input logic [31:0] p, input exp_t e);
      bit done;
      done = 1'b0;
      i_in_valid = 1'b1;
      i_instr    = ins;
      i_pc       = p;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (o_in_ready && !i_flush) begin
            e.pc = p;
            q.push_back(e);
            n_push++;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      i_in_valid = 1'b0;
      checks++;
      assert (done) else begin
         errors++;
         $error("FAIL accept_timeout instr %h got 0 exp 1", ins);
      end
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 50 && q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      assert (q.size() == 0) else begin
         errors++;
         $error("FAIL %s_drain got %0d pending exp 0", tag, q.size());
      end
   endtask

   task automatic check_cnt(input string tag);
      logic [15:0] e1;
      logic [1:0]  e2;
      e1 = 16'(exp_cnt);
      e2 = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
      checks++;
      assert (o_illegal_count === e1) else begin
         errors++;
         $error("FAIL %s_cnt16 got %0d exp %0d", tag, o_illegal_count, e1);
      end
      checks++;
      assert (o2_illegal_count === e2) else begin
         errors++;
         $error("FAIL %s_cnt2 got %0d exp %0d", tag, o2_illegal_count, e2);
      end
   endtask

   task automatic check_reset(input string tag);
      checks++;
      assert ({o_out_valid, o_in_ready, w_got, o_illegal_count, o2_illegal_count} ===
              {1'b0, 1'b1, 32'h0, 15'h0, 32'h0, 4'hF, 6'b000000, 16'h0, 2'h0}) else begin
         errors++;
         $error("FAIL %s got v%b r%b %h c%0d/%0d exp v0 r1 reset bundle c0/0", tag,
                o_out_valid, o_in_ready, w_got, o_illegal_count, o2_illegal_count);
      end
   endtask

   task automatic reset_dut();
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      q.delete();
      exp_cnt = 0;
   endtask

   initial begin
      int base;
      exp_t ea;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;
      check_reset("reset");

      // Full-rate stream of every instruction class, out_ready held high.
      i_out_ready = 1'b1;
      send(32'h002081B3, 32'h100, mk(5'd3,  5'd1,  5'd2,  32'h0,        4'h2, 6'b001000)); // ADD
      send(32'hFFF00093, 32'h104, mk(5'd1,  5'd0,  5'd31, 32'hFFFFFFFF, 4'h2, 6'b101000)); // ADDI -1
      send(32'h40335293, 32'h108, mk(5'd5,  5'd6,  5'd3,  32'h3,        4'h9, 6'b101000)); // SRAI
      send(32'hFE335293, 32'h10C, mk(5'd5,  5'd6,  5'd3,  32'h0,        4'hF, 6'b000001)); // bad funct7
      send(32'hFFC12383, 32'h110, mk(5'd7,  5'd2,  5'd28, 32'hFFFFFFFC, 4'h2, 6'b101100)); // LW
      send(32'h0050A423, 32'h114, mk(5'd8,  5'd1,  5'd5,  32'h8,        4'h2, 6'b100010)); // SW
      send(32'h12345537, 32'h118, mk(5'd10, 5'd0,  5'd3,  32'h12345000, 4'h2, 6'b101000)); // LUI
      send(32'h80000597, 32'h11C, mk(5'd11, 5'd0,  5'd0,  32'h80000000, 4'h2, 6'b111000)); // AUIPC
      send(32'h40628233, 32'h120, mk(5'd4,  5'd5,  5'd6,  32'h0,        4'h4, 6'b001000)); // SUB
      send(32'h4062E233, 32'h124, mk(5'd4,  5'd5,  5'd6,  32'h0,        4'hF, 6'b000001)); // OR, funct7 0x20
      send(32'hFFFFFFFF, 32'h128, mk(5'd31, 5'd31, 5'd31, 32'h0,        4'hF, 6'b000001)); // bad opcode
      drain("stream");
      check_cnt("stream");

      // Back-pressure: three instructions while execute stalls for four cycles.
      base = n_push;
      i_out_ready = 1'b0;
      ea = mk(5'd3, 5'd1, 5'd2, 32'h0, 4'h2, 6'b001000);
      held_e = ea;
      held_e.pc = 32'h200;
      fork
         begin
            send(32'h002081B3, 32'h200, ea);
            send(32'h40628233, 32'h204, mk(5'd4, 5'd5, 5'd6, 32'h0, 4'h4, 6'b001000));
            send(32'h0050A423, 32'h208, mk(5'd8, 5'd1, 5'd5, 32'h8, 4'h2, 6'b100010));
         end
      join_none
      @(posedge clk);
      #1;
      repeat (4) begin
         @(negedge clk);
         checks++;
         assert ({o_out_valid, o_in_ready, w_got} === {1'b1, 1'b0, held_e}) else begin
            errors++;
            $error("FAIL hold got v%b r%b %h exp v1 r0 %h", o_out_valid, o_in_ready, w_got, held_e);
         end
      end
      @(posedge clk);
      #1;
      i_out_ready = 1'b1;
      for (int k = 0; k < 50 && !(n_push == base + 3 && n_pop == n_push); k++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      assert (n_push == base + 3 && n_pop == n_push && q.size() == 0) else begin
         errors++;
         $error("FAIL backpressure_count got push %0d pop %0d exp %0d", n_push - base, n_pop, base + 3);
      end

      // Illegal counter: 3 handoffs, then 2 more to saturate the 2-bit copy.
      reset_dut();
      for (int k = 0; k < 3; k++)
         send(32'hFFFFFFFF, 32'h300 + 32'(k * 4), mk(5'd31, 5'd31, 5'd31, 32'h0, 4'hF, 6'b000001));
      drain("illegal3");
      check_cnt("illegal3");
      for (int k = 0; k < 2; k++)
         send(32'hFFFFFFFF, 32'h400 + 32'(k * 4), mk(5'd31, 5'd31, 5'd31, 32'h0, 4'hF, 6'b000001));
      drain("illegal5");
      check_cnt("illegal5");

      // Flush a held illegal bundle while a new instruction is offered.
      reset_dut();
      i_out_ready = 1'b0;
      send(32'hFFFFFFFF, 32'h500, mk(5'd31, 5'd31, 5'd31, 32'h0, 4'hF, 6'b000001));
      i_flush     = 1'b1;
      i_in_valid  = 1'b1;
      i_instr     = 32'h002081B3;
      i_pc        = 32'h504;
      i_out_ready = 1'b1;
      @(posedge clk);
      #1;
      i_flush    = 1'b0;
      i_in_valid = 1'b0;
      kill_e = q.pop_front();
      checks++;
      assert ({o_out_valid, o_illegal_count} === {1'b0, 16'd0}) else begin
         errors++;
         $error("FAIL flush got v%b c%0d exp v0 c0 (killed pc %h)", o_out_valid, o_illegal_count, kill_e.pc);
      end
      @(posedge clk);
      #1;
      checks++;
      assert (o_out_valid === 1'b0) else begin
         errors++;
         $error("FAIL flush_drop got %b exp 0", o_out_valid);
      end
      check_cnt("flush");

      // Reset mid-stream with a held bundle and a nonzero counter.
      send(32'hFFFFFFFF, 32'h600, mk(5'd31, 5'd31, 5'd31, 32'h0, 4'hF, 6'b000001));
      drain("pre_rst");
      i_out_ready = 1'b0;
      send(32'h12345537, 32'h604, mk(5'd10, 5'd0, 5'd3, 32'h12345000, 4'h2, 6'b101000));
      reset_dut();
      check_reset("mid_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
